wb_gpio_arb: RTL and testbench

- Two-master Wishbone arbiter that shares one GPIO slave (data reg at adr[2]=0, dir reg at adr[2]=1) between two requesters, e.g. CPU and a debug/boot master.
- Sits between the masters and the GPIO slave's Wishbone port.
- Round-robin grant with bus lock for as long as the granted master holds cyc.
- Routes ack/err/rty back only to the granted master.

---
 rtl/wb_gpio_arb_if.sv | 28 ++
 rtl/wb_gpio_arb.sv | 137 +++++++++++++
 tb/tb_wb_gpio_arb.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_gpio_arb_if.sv
// Wishbone classic bus bundle shared by the two requesting masters and the
// GPIO slave port of wb_gpio_arb.
//   master modport: the side that starts cycles (drives adr/dat_w/we/cyc/stb)
//   slave modport : the side that answers (drives dat_r/ack/err/rty)
interface wb_gpio_arb_if #(
  parameter int dw = 32,
  parameter int aw = 3
) ();
  logic [aw-1:0] adr;
  logic [dw-1:0] dat_w;
  logic [dw-1:0] dat_r;
  logic          we;
  logic          cyc;
  logic          stb;
  logic          ack;
  logic          err;
  logic          rty;

  modport master (
    output adr, dat_w, we, cyc, stb,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  adr, dat_w, we, cyc, stb,
    output dat_r, ack, err, rty
  );
endinterface

// File: rtl/wb_gpio_arb.sv
// Two-master Wishbone arbiter in front of a single GPIO slave.
// Round-robin grant from IDLE, bus locked to the granted master for as long
// as it holds cyc, responses routed only to the granted master. Every grant
// returns through IDLE, so there is always one dead cycle between owners.
// Optional response timeout: define WB_GPIO_ARB_TIMEOUT_EN to add an 8-bit
// watchdog that answers a silent slave with a one-cycle err to the master.
module wb_gpio_arb #(
  parameter int dw             = 32,
  parameter int aw             = 3,
  parameter int timeout_cycles = 16
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  wb_gpio_arb_if.slave  m0,
  wb_gpio_arb_if.slave  m1,
  wb_gpio_arb_if.master s
);

  if (dw < 1 || dw > 32 || aw < 1 || timeout_cycles < 2 || timeout_cycles > 255)
  begin : g_bad_param
    $error("wb_gpio_arb: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_gnt_q, last_gnt_d;   // master that received the most recent grant
  logic   to_hit;                   // watchdog fires this cycle

  // Next grant: round-robin only matters on a tie, and only from IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      IDLE: begin
        if (m0.cyc && (!m1.cyc || last_gnt_q)) begin
          state_d    = GNT0;
          last_gnt_d = 1'b0;
        end else if (m1.cyc) begin
          state_d    = GNT1;
          last_gnt_d = 1'b1;
        end
      end
      GNT0:    if (!m0.cyc) state_d = IDLE;
      GNT1:    if (!m1.cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant state and round-robin pointer; master 0 wins the first tie.
  always_ff @(posedge wb_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (wb_rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

`ifdef WB_GPIO_ARB_TIMEOUT_EN
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       s_resp;

  assign s_resp = s.ack | s.err | s.rty;
  assign to_hit = (state_q != IDLE) && (to_cnt_q == 8'(timeout_cycles));

  // Count strobed cycles without an answer; held at zero while idle so each grant starts fresh.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == IDLE || s_resp || to_hit) begin
      to_cnt_d = 8'd0;
    end else if (s.stb) begin
      to_cnt_d = to_cnt_q + 8'd1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      to_cnt_q <= 8'd0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // Bus and response routing: the granted master is wired straight through,
  // everyone else sees a quiet bus. A timeout swaps the strobe for an err.
  always_comb begin
    s.adr    = '0;
    s.dat_w  = '0;
    s.we     = 1'b0;
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m0.rty   = 1'b0;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m1.rty   = 1'b0;
    m0.dat_r = s.dat_r;
    m1.dat_r = s.dat_r;
    case (state_q)
      GNT0: begin
        s.adr   = m0.adr;
        s.dat_w = m0.dat_w;
        s.we    = m0.we;
        s.cyc   = m0.cyc;
        s.stb   = m0.stb & ~to_hit;
        m0.ack  = s.ack;
        m0.err  = s.err | to_hit;
        m0.rty  = s.rty;
      end
      GNT1: begin
        s.adr   = m1.adr;
        s.dat_w = m1.dat_w;
        s.we    = m1.we;
        s.cyc   = m1.cyc;
        s.stb   = m1.stb & ~to_hit;
        m1.ack  = s.ack;
        m1.err  = s.err | to_hit;
        m1.rty  = s.rty;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_gpio_arb.sv
// Bench for wb_gpio_arb: two scripted masters, a GPIO slave with a
// registered ack, and a reference model (register file plus round-robin
// pointer) that predicts the winner of each contest and every read value.
module tb_wb_gpio_arb;
  localparam int DW = 32;
  localparam int AW = 3;

  typedef struct packed {
    logic        we;
    logic [2:0]  adr;
    logic [31:0] dat;
  } xfer_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_gpio_arb_if #(.dw(DW), .aw(AW)) m0_bus ();
  wb_gpio_arb_if #(.dw(DW), .aw(AW)) m1_bus ();
  wb_gpio_arb_if #(.dw(DW), .aw(AW)) s_bus ();

  wb_gpio_arb #(.dw(DW), .aw(AW), .timeout_cycles(4)) dut (
    .wb_clk (clk),
    .wb_rst (rst),
    .m0     (m0_bus),
    .m1     (m1_bus),
    .s      (s_bus)
  );

  // GPIO slave: data reg at adr[2]=0, dir reg at adr[2]=1, one-cycle registered ack.
  // It is deliberately not reset so an ack can be in flight across a reset.
  logic [31:0] gpio_data = '0;
  logic [31:0] gpio_dir  = '0;
  logic [31:0] s_rdat    = '0;
  logic        s_ack_q   = 1'b0;
  logic        slave_mute = 1'b0;
  logic        err_inj   = 1'b0;
  logic        rty_inj   = 1'b0;

  always @(posedge clk) begin
    if (s_bus.cyc && s_bus.stb && !s_ack_q && !slave_mute) begin
      s_ack_q <= 1'b1;
      s_rdat  <= s_bus.adr[2] ? gpio_dir : gpio_data;
      if (s_bus.we) begin
        if (s_bus.adr[2]) gpio_dir  <= s_bus.dat_w;
        else              gpio_data <= s_bus.dat_w;
      end
    end else begin
      s_ack_q <= 1'b0;
    end
  end

  assign s_bus.dat_r = s_rdat;
  assign s_bus.ack   = s_ack_q;
  assign s_bus.err   = err_inj;
  assign s_bus.rty   = rty_inj;

  // Cycle counter and ack monitor.
  int cyc_no  = 0;
  int m0_acks = 0;
  int m1_acks = 0;
  always @(posedge clk) cyc_no <= cyc_no + 1;
  always @(negedge clk) begin
    if (m0_bus.ack === 1'b1) m0_acks++;
    if (m1_bus.ack === 1'b1) m1_acks++;
  end

  // Reference model.
  logic [31:0] model_regs [2] = '{32'h0, 32'h0};
  int          model_last = 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input bit cyc, input bit stb, input xfer_t x);
    if (m == 0) begin
      m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = x.we;
      m0_bus.adr = x.adr; m0_bus.dat_w = x.dat;
    end else begin
      m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = x.we;
      m1_bus.adr = x.adr; m1_bus.dat_w = x.dat;
    end
  endtask

  function automatic xfer_t rand_xfer();
    xfer_t x;
    x.we  = 1'($urandom_range(0, 1));
    x.adr = 3'($urandom_range(0, 7));
    x.dat = $urandom;
    return x;
  endfunction

  // Wait (bounded) for an ack on master m; 'at' is the cycle it was seen, -1 on timeout.
  task automatic wait_m(input int m, output int at, output logic [31:0] rd);
    at = -1;
    rd = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (((m == 0) ? m0_bus.ack : m1_bus.ack) === 1'b1) begin
        at = cyc_no;
        rd = (m == 0) ? m0_bus.dat_r : m1_bus.dat_r;
        break;
      end
    end
    step();
  endtask

  // Wait (bounded) for the first ack on either master; got = 0/1, 2 if both, -1 on timeout.
  task automatic wait_any(output int got, output int at, output logic [31:0] rd);
    got = -1;
    at  = -1;
    rd  = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m0_bus.ack === 1'b1 || m1_bus.ack === 1'b1) begin
        got = (m0_bus.ack === 1'b1 && m1_bus.ack === 1'b1) ? 2 : (m0_bus.ack === 1'b1 ? 0 : 1);
        at  = cyc_no;
        rd  = (got == 1) ? m1_bus.dat_r : m0_bus.dat_r;
        break;
      end
    end
    step();
  endtask

  // Apply a completed transfer to the model, checking read data against it.
  task automatic settle_xfer(input string tag, input xfer_t x, input logic [31:0] rd);
    if (x.we) model_regs[x.adr[2]] = x.dat;
    else      check({tag, "_rdata"}, rd, model_regs[x.adr[2]]);
  endtask

  // One contest: requested masters raise cyc+stb on the same edge.
  // Release to IDLE takes an edge, IDLE a cycle, grant an edge and the slave
  // a cycle, so a waiting loser's ack lands 4 cycles after the winner's.
  task automatic race(input string tag, input bit r0, input bit r1, input bit loser_stays,
                      input xfer_t x0, input xfer_t x1);
    int          first, got, t1, t2;
    logic [31:0] rd;
    xfer_t       xf, xs;
    first      = (r0 && r1) ? 1 - model_last : (r0 ? 0 : 1);
    model_last = first;
    xf = (first == 0) ? x0 : x1;
    xs = (first == 0) ? x1 : x0;
    if (r0) drive(0, 1'b1, 1'b1, x0);
    if (r1) drive(1, 1'b1, 1'b1, x1);
    wait_any(got, t1, rd);
    check({tag, "_winner"}, got, first);
    settle_xfer(tag, xf, rd);
    drive(first, 1'b0, 1'b0, '0);
    if (r0 && r1) begin
      if (loser_stays) begin
        wait_m(1 - first, t2, rd);
        check({tag, "_regrant_gap"}, t2 - t1, 4);
        settle_xfer(tag, xs, rd);
        model_last = 1 - first;
      end
      drive(1 - first, 1'b0, 1'b0, '0);
    end
    step();
    step();
  endtask

  task automatic reset_dut();
    drive(0, 1'b0, 1'b0, '0);
    drive(1, 1'b0, 1'b0, '0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_last = 1;
    step();
  endtask

  initial begin
    int          t0, t, t3, a0, a1, first_err, n_err, n_err1;
    logic        stb_at_hit;
    logic [31:0] rd, v;
    xfer_t       x, xa, xb;

    // Reset: m0 requests throughout, the arbiter must stay quiet.
    drive(0, 1'b1, 1'b1, '{we: 1'b1, adr: 3'd5, dat: 32'hDEADBEEF});
    drive(1, 1'b0, 1'b0, '0);
    step(); step(); step();
    @(negedge clk);
    check("rst_s_ctrl", {s_bus.cyc, s_bus.stb, s_bus.we}, 3'b000);
    check("rst_s_adr",  s_bus.adr, 3'd0);
    check("rst_s_dat",  s_bus.dat_w, 32'h0);
    check("rst_m_resp", {m0_bus.ack, m0_bus.err, m0_bus.rty, m1_bus.ack, m1_bus.err, m1_bus.rty}, 6'b0);
    drive(0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    step();

    // m0 writes 0xA5 to the data register.
    x  = '{we: 1'b1, adr: 3'd0, dat: 32'hA5};
    a0 = m0_acks; a1 = m1_acks; t0 = cyc_no;
    drive(0, 1'b1, 1'b1, x);
    model_last = 0;
    @(negedge clk);
    check("t1_no_early_grant", s_bus.cyc, 1'b0);
    step();
    @(negedge clk);
    check("t1_s_cyc", s_bus.cyc, 1'b1);
    check("t1_s_dat", s_bus.dat_w, 32'hA5);
    check("t1_s_we",  s_bus.we, 1'b1);
    wait_m(0, t, rd);
    check("t1_ack_latency", t - t0, 2);
    settle_xfer("t1", x, rd);
    drive(0, 1'b0, 1'b0, '0);
    step(); step();
    check("t1_gpio", gpio_data, 32'hA5);
    check("t1_m0_ack_once", m0_acks - a0, 1);
    check("t1_m1_no_ack", m1_acks - a1, 0);

    // Tie right after reset: m0 writes dir, then m1 reads it back.
    reset_dut();
    v = $urandom;
    race("tie", 1'b1, 1'b1, 1'b1,
         '{we: 1'b1, adr: 3'd4, dat: v}, '{we: 1'b0, adr: 3'd4, dat: 32'h0});
    check("tie_dir_reg", model_regs[1], v);

    // Bus lock: m0 holds cyc over three transfers while m1 waits.
    a0 = m0_acks; a1 = m1_acks;
    xa = rand_xfer();
    drive(0, 1'b1, 1'b1, xa);
    model_last = 0;
    step();
    xb = '{we: 1'b0, adr: 3'd4, dat: 32'h0};
    drive(1, 1'b1, 1'b1, xb);
    t3 = -1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        xa = rand_xfer();
        drive(0, 1'b1, 1'b1, xa);
      end
      wait_m(0, t3, rd);
      settle_xfer("lock", xa, rd);
    end
    drive(0, 1'b0, 1'b0, '0);
    check("lock_m0_acks", m0_acks - a0, 3);
    check("lock_m1_starved", m1_acks - a1, 0);
    @(negedge clk);
    check("lock_release_cyc", s_bus.cyc, 1'b0);
    step();
    @(negedge clk);
    check("lock_idle_gap", s_bus.cyc, 1'b0);
    step();
    @(negedge clk);
    check("lock_m1_granted", s_bus.cyc, 1'b1);
    check("lock_m1_adr", s_bus.adr, 3'd4);
    wait_m(1, t, rd);
    check("lock_m1_ack_delay", t - t3, 4);
    settle_xfer("lock_m1", xb, rd);
    model_last = 1;
    drive(1, 1'b0, 1'b0, '0);
    step(); step();

    // Four contests where the loser withdraws: winners must alternate.
    for (int k = 0; k < 4; k++) begin
      race("alt", 1'b1, 1'b1, 1'b0, rand_xfer(), rand_xfer());
    end

    // Randomized mix of single requests and contests.
    for (int k = 0; k < 16; k++) begin
      int r;
      r = int'($urandom_range(1, 3));
      race("rnd", r[0], r[1], 1'($urandom_range(0, 1)), rand_xfer(), rand_xfer());
    end

    // Response routing: err/rty reach only the granted master, and nobody in IDLE.
    x = rand_xfer();
    drive(1, 1'b1, 1'b0, x);
    model_last = 1;
    step();
    @(negedge clk);
    check("route_s_adr", s_bus.adr, x.adr);
    check("route_s_dat", s_bus.dat_w, x.dat);
    step();
    err_inj = 1'b1; rty_inj = 1'b1;
    @(negedge clk);
    check("route_m1_resp", {m1_bus.err, m1_bus.rty}, 2'b11);
    check("route_m0_quiet", {m0_bus.err, m0_bus.rty}, 2'b00);
    step();
    err_inj = 1'b0; rty_inj = 1'b0;
    drive(1, 1'b0, 1'b0, '0);
    step(); step();
    err_inj = 1'b1; rty_inj = 1'b1;
    @(negedge clk);
    check("idle_resp_dropped", {m0_bus.err, m0_bus.rty, m1_bus.err, m1_bus.rty}, 4'b0);
    step();
    err_inj = 1'b0; rty_inj = 1'b0;

    // Reset one cycle before the slave ack: the ack must not reach anyone.
    a0 = m0_acks; a1 = m1_acks;
    x = rand_xfer();
    x.we = 1'b0;
    drive(0, 1'b1, 1'b1, x);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_granted", s_bus.cyc, 1'b1);
    step();
    @(negedge clk);
    check("rstmid_s_cyc_stb", {s_bus.cyc, s_bus.stb}, 2'b00);
    check("rstmid_acks", {m0_bus.ack, m1_bus.ack}, 2'b00);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, '0);
    model_last = 1;
    step();
    @(negedge clk);
    check("rstmid_idle", s_bus.cyc, 1'b0);
    check("rstmid_no_ack_count", (m0_acks - a0) + (m1_acks - a1), 0);
    step();
    race("post_rst_tie", 1'b1, 1'b1, 1'b0, rand_xfer(), rand_xfer());

    // Silent slave: with the watchdog, err pulses 4 cycles after stb first shows.
    slave_mute = 1'b1;
    first_err = -1; n_err = 0; n_err1 = 0; stb_at_hit = 1'b0;
    drive(0, 1'b1, 1'b1, '{we: 1'b0, adr: 3'd0, dat: 32'h0});
    model_last = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      @(negedge clk);
      if (m0_bus.err === 1'b1) begin
        n_err++;
        if (first_err < 0) first_err = i - 1;
      end
      if (m1_bus.err === 1'b1) n_err1++;
      if (i == 5) stb_at_hit = s_bus.stb;
    end
`ifdef WB_GPIO_ARB_TIMEOUT_EN
    check("to_err_delay", first_err, 4);
    check("to_err_pulses", n_err, 1);
    check("to_stb_forced", stb_at_hit, 1'b0);
`else
    check("to_no_err", n_err, 0);
    check("to_stb_kept", stb_at_hit, 1'b1);
`endif
    check("to_m1_quiet", n_err1, 0);
    drive(0, 1'b0, 1'b0, '0);
    step(); step();
    slave_mute = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
